axi_nsaid_tagger: RTL and testbench

- Sits between one non-CPU AXI master (DMA, peripheral bridge) and the IOPMP.
- Forwards every channel unchanged and stamps AW/AR with a configurable non-secure agent ID (`nsaid`).
- Counts outstanding reads and writes, and stalls new requests at a configurable limit.
- Applies NSAID reconfiguration only at a quiescent point: new requests are blocked and in-flight transactions drain first. No transaction is ever tagged with a mix of old and new ID.

---
 rtl/axi_nsaid_tagger.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_axi_nsaid_tagger.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_nsaid_tagger.sv
// AXI NSAID tagger: passes a non-CPU master's AXI traffic through to the IOPMP, stamps AW/AR with
// the active non-secure agent ID, limits outstanding transactions and switches IDs only when quiescent.
package axi_nsaid_pkg;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned DataW  = 32;
    localparam int unsigned IdW    = 4;
    localparam int unsigned UserW  = 1;
    localparam int unsigned NsaidW = 4;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [5:0]       atop;
        logic [UserW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [IdW-1:0]    id;
        logic [AddrW-1:0]  addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [UserW-1:0]  user;
        logic [NsaidW-1:0] nsaid;
    } aw_nsaid_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdW-1:0]    id;
        logic [AddrW-1:0]  addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [UserW-1:0]  user;
        logic [NsaidW-1:0] nsaid;
    } ar_nsaid_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        aw_nsaid_chan_t aw;
        logic           aw_valid;
        w_chan_t        w;
        logic           w_valid;
        logic           b_ready;
        ar_nsaid_chan_t ar;
        logic           ar_valid;
        logic           r_ready;
    } req_nsaid_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_nsaid_tagger #(
    parameter int unsigned            NsaidWidth = 4,
    parameter int unsigned            MaxTxns    = 8,
    parameter logic [NsaidWidth-1:0]  ResetNsaid = '0,
    parameter type                    slv_req_t  = axi_nsaid_pkg::req_t,
    parameter type                    mst_req_t  = axi_nsaid_pkg::req_nsaid_t,
    parameter type                    resp_t     = axi_nsaid_pkg::resp_t,
    localparam int unsigned           CntW       = $clog2(MaxTxns + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  slv_req_t              slv_req_i,
    output resp_t                 slv_resp_o,
    output mst_req_t              mst_req_o,
    input  resp_t                 mst_resp_i,
    input  logic                  cfg_valid_i,
    input  logic [NsaidWidth-1:0] cfg_nsaid_i,
    output logic                  cfg_busy_o,
    output logic [NsaidWidth-1:0] nsaid_o,
    output logic [CntW-1:0]       wr_cnt_o,
    output logic [CntW-1:0]       rd_cnt_o
);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    typedef enum logic {StRun = 1'b0, StDrain = 1'b1} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [NsaidWidth-1:0] r_nsaid;
    logic [NsaidWidth-1:0] r_nsaid_pend;
    logic [CntW-1:0]       r_wr_cnt;
    logic [CntW-1:0]       r_rd_cnt;
    logic                  r_aw_pend;
    logic                  r_ar_pend;

    logic w_drain;
    logic w_quiet;
    logic w_aw_atomic;
    logic w_rd_full_aw;
    logic w_aw_block;
    logic w_ar_block;
    logic w_mst_aw_valid;
    logic w_mst_ar_valid;
    logic w_aw_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_last_hs;
    logic [1:0] w_rd_inc;

    // Saturating count update; clamps at both ends so the counter can never wrap.
    function automatic logic [CntW-1:0] sat_cnt(input logic [CntW-1:0] cnt,
                                                input logic [1:0]      inc,
                                                input logic            dec);
        logic [CntW+1:0] v;
        v = {2'b00, cnt} + {{CntW{1'b0}}, inc};
        if (dec) begin
            v = (v == '0) ? '0 : v - (CntW+2)'(1);
        end
        if (v > {2'b00, MaxCnt}) begin
            v = {2'b00, MaxCnt};
        end
        return v[CntW-1:0];
    endfunction

    assign w_aw_atomic  = slv_req_i.aw.atop[5];
    // An atomic AW needs two read slots, since an AR may be accepted in the same cycle.
    assign w_rd_full_aw = w_aw_atomic ? (({1'b0, r_rd_cnt} + (CntW+1)'(2)) > {1'b0, MaxCnt})
                                      : (r_rd_cnt == MaxCnt);
    assign w_aw_block   = !r_aw_pend && (w_drain || (r_wr_cnt == MaxCnt) || w_rd_full_aw);
    assign w_ar_block   = !r_ar_pend && (w_drain || (r_rd_cnt == MaxCnt));

    assign w_mst_aw_valid = slv_req_i.aw_valid && !w_aw_block;
    assign w_mst_ar_valid = slv_req_i.ar_valid && !w_ar_block;
    assign w_aw_hs        = w_mst_aw_valid && mst_resp_i.aw_ready;
    assign w_ar_hs        = w_mst_ar_valid && mst_resp_i.ar_ready;
    assign w_b_hs         = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign w_r_last_hs    = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign w_rd_inc       = {1'b0, w_ar_hs} + {1'b0, w_aw_hs && w_aw_atomic};
    assign w_quiet        = (r_wr_cnt == '0) && (r_rd_cnt == '0) && !r_aw_pend && !r_ar_pend;

    always_comb begin
        mst_req_o           = '0;
        mst_req_o.aw.id     = slv_req_i.aw.id;
        mst_req_o.aw.addr   = slv_req_i.aw.addr;
        mst_req_o.aw.len    = slv_req_i.aw.len;
        mst_req_o.aw.size   = slv_req_i.aw.size;
        mst_req_o.aw.burst  = slv_req_i.aw.burst;
        mst_req_o.aw.lock   = slv_req_i.aw.lock;
        mst_req_o.aw.cache  = slv_req_i.aw.cache;
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.qos    = slv_req_i.aw.qos;
        mst_req_o.aw.region = slv_req_i.aw.region;
        mst_req_o.aw.atop   = slv_req_i.aw.atop;
        mst_req_o.aw.user   = slv_req_i.aw.user;
        mst_req_o.aw.nsaid  = r_nsaid;
        mst_req_o.aw_valid  = w_mst_aw_valid;
        mst_req_o.w         = slv_req_i.w;
        mst_req_o.w_valid   = slv_req_i.w_valid;
        mst_req_o.b_ready   = slv_req_i.b_ready;
        mst_req_o.ar.id     = slv_req_i.ar.id;
        mst_req_o.ar.addr   = slv_req_i.ar.addr;
        mst_req_o.ar.len    = slv_req_i.ar.len;
        mst_req_o.ar.size   = slv_req_i.ar.size;
        mst_req_o.ar.burst  = slv_req_i.ar.burst;
        mst_req_o.ar.lock   = slv_req_i.ar.lock;
        mst_req_o.ar.cache  = slv_req_i.ar.cache;
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.qos    = slv_req_i.ar.qos;
        mst_req_o.ar.region = slv_req_i.ar.region;
        mst_req_o.ar.user   = slv_req_i.ar.user;
        mst_req_o.ar.nsaid  = r_nsaid;
        mst_req_o.ar_valid  = w_mst_ar_valid;
        mst_req_o.r_ready   = slv_req_i.r_ready;
    end

    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !w_aw_block;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !w_ar_block;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (cfg_valid_i) w_state_nxt = StDrain;
            StDrain: if (w_quiet)     w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    always_comb begin
        w_drain    = (r_state == StDrain);
        cfg_busy_o = w_drain;
    end

    // A request arriving on the very cycle the drain completes goes straight into the active ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nsaid   <= ResetNsaid;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_aw_pend <= 1'b0;
            r_ar_pend <= 1'b0;
        end else begin
            if (w_drain && w_quiet) begin
                r_nsaid <= cfg_valid_i ? cfg_nsaid_i : r_nsaid_pend;
            end
            r_wr_cnt <= sat_cnt(r_wr_cnt, {1'b0, w_aw_hs}, w_b_hs);
            r_rd_cnt <= sat_cnt(r_rd_cnt, w_rd_inc, w_r_last_hs);
            if (w_aw_hs) begin
                r_aw_pend <= 1'b0;
            end else if (w_mst_aw_valid) begin
                r_aw_pend <= 1'b1;
            end
            if (w_ar_hs) begin
                r_ar_pend <= 1'b0;
            end else if (w_mst_ar_valid) begin
                r_ar_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cfg_valid_i) begin
            r_nsaid_pend <= cfg_nsaid_i;
        end
    end

    assign nsaid_o  = r_nsaid;
    assign wr_cnt_o = r_wr_cnt;
    assign rd_cnt_o = r_rd_cnt;

    // A response with nothing outstanding means the master or IOPMP broke the protocol.
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_b_hs && !w_aw_hs && (r_wr_cnt == '0)));
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_r_last_hs && (w_rd_inc == 2'd0) && (r_rd_cnt == '0)));
endmodule

// File: tb/tb_axi_nsaid_tagger.sv
// Directed bench for axi_nsaid_tagger with a cycle-level reference model checked every negedge.
module tb_axi_nsaid_tagger;
    import axi_nsaid_pkg::*;

    localparam int         MAX       = 2;
    localparam logic [3:0] RST_NSAID = 4'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    req_t       slv_req;
    resp_t      slv_resp;
    req_nsaid_t mst_req;
    resp_t      mst_resp;
    logic       cfg_valid;
    logic [3:0] cfg_nsaid;
    logic       cfg_busy;
    logic [3:0] nsaid;
    logic [1:0] wr_cnt;
    logic [1:0] rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_nsaid_tagger #(
        .NsaidWidth (4),
        .MaxTxns    (MAX),
        .ResetNsaid (RST_NSAID)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .cfg_valid_i (cfg_valid),
        .cfg_nsaid_i (cfg_nsaid),
        .cfg_busy_o  (cfg_busy),
        .nsaid_o     (nsaid),
        .wr_cnt_o    (wr_cnt),
        .rd_cnt_o    (rd_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding counts, active/pending ID and drain flag as plain integers.
    int         m_wr, m_rd;
    logic [3:0] m_nsaid, m_pend;
    bit         m_drain, m_awp, m_arp;

    initial begin
        forever begin
            bit atomic, aw_ok, ar_ok, aw_fire, ar_fire, b_fire, r_fire, quiet_now;
            @(negedge clk);
            if (!rst_n) begin
                m_wr = 0; m_rd = 0; m_nsaid = RST_NSAID; m_pend = '0;
                m_drain = 0; m_awp = 0; m_arp = 0;
            end
            atomic = slv_req.aw.atop[5];
            aw_ok  = m_awp || (!m_drain && (m_wr < MAX) &&
                               (atomic ? (m_rd + 2 <= MAX) : (m_rd < MAX)));
            ar_ok  = m_arp || (!m_drain && (m_rd < MAX));

            check("aw_valid", 32'(mst_req.aw_valid), 32'(slv_req.aw_valid && aw_ok));
            check("aw_ready", 32'(slv_resp.aw_ready), 32'(mst_resp.aw_ready && aw_ok));
            check("ar_valid", 32'(mst_req.ar_valid), 32'(slv_req.ar_valid && ar_ok));
            check("ar_ready", 32'(slv_resp.ar_ready), 32'(mst_resp.ar_ready && ar_ok));
            if (slv_req.aw_valid && aw_ok) check("aw_nsaid", 32'(mst_req.aw.nsaid), 32'(m_nsaid));
            if (slv_req.ar_valid && ar_ok) check("ar_nsaid", 32'(mst_req.ar.nsaid), 32'(m_nsaid));
            check("aw_addr", mst_req.aw.addr, slv_req.aw.addr);
            check("aw_atop", 32'(mst_req.aw.atop), 32'(slv_req.aw.atop));
            check("ar_addr", mst_req.ar.addr, slv_req.ar.addr);
            check("w_valid", 32'(mst_req.w_valid), 32'(slv_req.w_valid));
            check("w_data", mst_req.w.data, slv_req.w.data);
            check("w_ready", 32'(slv_resp.w_ready), 32'(mst_resp.w_ready));
            check("b_valid", 32'(slv_resp.b_valid), 32'(mst_resp.b_valid));
            check("r_valid", 32'(slv_resp.r_valid), 32'(mst_resp.r_valid));
            check("r_last", 32'(slv_resp.r.last), 32'(mst_resp.r.last));
            check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
            check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
            check("nsaid_o", 32'(nsaid), 32'(m_nsaid));
            check("cfg_busy", 32'(cfg_busy), 32'(m_drain));

            if (rst_n) begin
                aw_fire   = slv_req.aw_valid && mst_resp.aw_ready && aw_ok;
                ar_fire   = slv_req.ar_valid && mst_resp.ar_ready && ar_ok;
                b_fire    = mst_resp.b_valid && slv_req.b_ready;
                r_fire    = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
                quiet_now = (m_wr == 0) && (m_rd == 0) && !m_awp && !m_arp;
                if (!m_drain) begin
                    if (cfg_valid) begin
                        m_pend  = cfg_nsaid;
                        m_drain = 1;
                    end
                end else if (quiet_now) begin
                    m_nsaid = cfg_valid ? cfg_nsaid : m_pend;
                    m_drain = 0;
                end else if (cfg_valid) begin
                    m_pend = cfg_nsaid;
                end
                m_wr = m_wr + int'(aw_fire) - int'(b_fire);
                m_rd = m_rd + int'(ar_fire) + int'(aw_fire && atomic) - int'(r_fire);
                if (aw_fire) m_awp = 0; else if (slv_req.aw_valid && aw_ok) m_awp = 1;
                if (ar_fire) m_arp = 0; else if (slv_req.ar_valid && ar_ok) m_arp = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Default per-cycle drive: no valids, every ready high.
    task automatic quiet();
        slv_req           = '0;
        mst_resp          = '0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        cfg_valid         = 1'b0;
        cfg_nsaid         = '0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [5:0] atop);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = addr;
        slv_req.aw.atop  = atop;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = addr;
    endtask

    task automatic send_r_last();
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        slv_req   = '0;
        mst_resp  = '0;
        cfg_valid = 1'b0;
        cfg_nsaid = '0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_nsaid", 32'(nsaid), 32'd3);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_wr", 32'(wr_cnt), 32'd0);
        check("rst_rd", 32'(rd_cnt), 32'd0);
        check("rst_aw_valid", 32'(mst_req.aw_valid), 32'd0);
        check("rst_aw_ready", 32'(slv_resp.aw_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write, zero-latency pass-through
        cyc(); quiet(); send_aw(32'h1000, 6'd0);
        slv_req.w_valid = 1'b1; slv_req.w.data = 32'hCAFE_0001; slv_req.w.last = 1'b1;
        settle();
        check("t1_aw_valid", 32'(mst_req.aw_valid), 32'd1);
        check("t1_aw_nsaid", 32'(mst_req.aw.nsaid), 32'd3);
        check("t1_aw_ready", 32'(slv_resp.aw_ready), 32'd1);
        check("t1_aw_addr", mst_req.aw.addr, 32'h1000);
        cyc(); quiet(); settle();
        check("t1_wr_after_aw", 32'(wr_cnt), 32'd1);
        cyc(); quiet(); mst_resp.b_valid = 1'b1; settle();
        check("t1_b_valid", 32'(slv_resp.b_valid), 32'd1);
        check("t1_wr_during_b", 32'(wr_cnt), 32'd1);
        cyc(); quiet(); settle();
        check("t1_wr_after_b", 32'(wr_cnt), 32'd0);

        // Read limit at MaxTxns=2
        cyc(); quiet(); send_ar(32'h2000); settle();
        check("t2_ar0_ready", 32'(slv_resp.ar_ready), 32'd1);
        cyc(); quiet(); send_ar(32'h2004);
        cyc(); quiet(); send_ar(32'h2008); settle();
        check("t2_ar2_ready", 32'(slv_resp.ar_ready), 32'd0);
        check("t2_ar2_valid", 32'(mst_req.ar_valid), 32'd0);
        check("t2_rd_full", 32'(rd_cnt), 32'd2);
        cyc(); quiet(); send_ar(32'h2008); send_r_last(); settle();
        check("t2_ar2_still_blocked", 32'(slv_resp.ar_ready), 32'd0);
        cyc(); quiet(); send_ar(32'h2008); settle();
        check("t2_rd_freed", 32'(rd_cnt), 32'd1);
        check("t2_ar2_accepted", 32'(slv_resp.ar_ready), 32'd1);
        cyc(); quiet(); send_r_last();
        cyc(); quiet(); send_r_last();
        cyc(); quiet(); settle();
        check("t2_rd_zero", 32'(rd_cnt), 32'd0);

        // Reconfigure with two writes outstanding
        cyc(); quiet(); send_aw(32'h3000, 6'd0);
        cyc(); quiet(); send_aw(32'h3100, 6'd0);
        cyc(); quiet(); cfg_valid = 1'b1; cfg_nsaid = 4'd5; settle();
        check("t3_wr2", 32'(wr_cnt), 32'd2);
        check("t3_busy_t", 32'(cfg_busy), 32'd0);
        cyc(); quiet(); send_ar(32'h4000); mst_resp.b_valid = 1'b1; settle();
        check("t3_busy_t1", 32'(cfg_busy), 32'd1);
        check("t3_ar_gated", 32'(mst_req.ar_valid), 32'd0);
        check("t3_ar_stall", 32'(slv_resp.ar_ready), 32'd0);
        cyc(); quiet(); send_ar(32'h4000); mst_resp.b_valid = 1'b1; settle();
        check("t3_nsaid_old1", 32'(nsaid), 32'd3);
        cyc(); quiet(); send_ar(32'h4000); settle();
        check("t3_wr0", 32'(wr_cnt), 32'd0);
        check("t3_nsaid_old2", 32'(nsaid), 32'd3);
        check("t3_ar_stall2", 32'(slv_resp.ar_ready), 32'd0);
        cyc(); quiet(); send_ar(32'h4000); settle();
        check("t3_nsaid_new", 32'(nsaid), 32'd5);
        check("t3_busy_done", 32'(cfg_busy), 32'd0);
        check("t3_ar_out", 32'(mst_req.ar_valid), 32'd1);
        check("t3_ar_nsaid", 32'(mst_req.ar.nsaid), 32'd5);
        cyc(); quiet(); send_r_last();
        cyc(); quiet(); settle();
        check("t3_rd0", 32'(rd_cnt), 32'd0);

        // AW stalled at the IOPMP when the change arrives
        cyc(); quiet(); send_aw(32'h5000, 6'd0); mst_resp.aw_ready = 1'b0; settle();
        check("t4_aw_held", 32'(mst_req.aw_valid), 32'd1);
        cyc(); quiet(); send_aw(32'h5000, 6'd0); mst_resp.aw_ready = 1'b0;
        cfg_valid = 1'b1; cfg_nsaid = 4'd7;
        cyc(); quiet(); send_aw(32'h5000, 6'd0); settle();
        check("t4_busy", 32'(cfg_busy), 32'd1);
        check("t4_aw_not_withdrawn", 32'(mst_req.aw_valid), 32'd1);
        check("t4_aw_old_nsaid", 32'(mst_req.aw.nsaid), 32'd5);
        check("t4_aw_hs", 32'(slv_resp.aw_ready), 32'd1);
        cyc(); quiet(); mst_resp.b_valid = 1'b1; settle();
        check("t4_wr1", 32'(wr_cnt), 32'd1);
        cyc(); quiet(); settle();
        check("t4_still_busy", 32'(cfg_busy), 32'd1);
        check("t4_nsaid_old", 32'(nsaid), 32'd5);
        cyc(); quiet(); settle();
        check("t4_nsaid_new", 32'(nsaid), 32'd7);

        // Atomic AW occupies a write and a read slot
        cyc(); quiet(); send_aw(32'h6000, 6'b100000);
        cyc(); quiet(); settle();
        check("t5_wr", 32'(wr_cnt), 32'd1);
        check("t5_rd", 32'(rd_cnt), 32'd1);
        cyc(); quiet(); mst_resp.b_valid = 1'b1;
        cyc(); quiet(); settle();
        check("t5_wr_after_b", 32'(wr_cnt), 32'd0);
        check("t5_rd_after_b", 32'(rd_cnt), 32'd1);
        cyc(); quiet(); send_r_last();
        cyc(); quiet(); settle();
        check("t5_rd_after_r", 32'(rd_cnt), 32'd0);

        // AR plus atomic AW in one cycle, then the two-slot rule
        cyc(); quiet(); send_aw(32'h7000, 6'b100000); send_ar(32'h7100); settle();
        check("t7_aw_ok", 32'(slv_resp.aw_ready), 32'd1);
        check("t7_ar_ok", 32'(slv_resp.ar_ready), 32'd1);
        cyc(); quiet(); send_r_last(); settle();
        check("t7_rd2", 32'(rd_cnt), 32'd2);
        cyc(); quiet(); send_aw(32'h7200, 6'b100000); mst_resp.b_valid = 1'b1; settle();
        check("t7_rd1", 32'(rd_cnt), 32'd1);
        check("t7_atomic_blocked", 32'(slv_resp.aw_ready), 32'd0);
        cyc(); quiet(); send_aw(32'h7300, 6'd0); send_r_last(); settle();
        check("t7_plain_ok", 32'(slv_resp.aw_ready), 32'd1);
        cyc(); quiet(); mst_resp.b_valid = 1'b1;
        cyc(); quiet(); settle();
        check("t7_wr0", 32'(wr_cnt), 32'd0);
        check("t7_rd0", 32'(rd_cnt), 32'd0);

        // Two config pulses in one drain: last write wins
        cyc(); quiet(); send_aw(32'h8000, 6'd0);
        cyc(); quiet(); cfg_valid = 1'b1; cfg_nsaid = 4'd6;
        cyc(); quiet(); cfg_valid = 1'b1; cfg_nsaid = 4'd9; settle();
        check("t6_busy", 32'(cfg_busy), 32'd1);
        cyc(); quiet(); mst_resp.b_valid = 1'b1;
        cyc(); quiet(); settle();
        check("t6_busy_drain", 32'(cfg_busy), 32'd1);
        check("t6_nsaid_old", 32'(nsaid), 32'd7);
        cyc(); quiet(); settle();
        check("t6_nsaid_9", 32'(nsaid), 32'd9);
        check("t6_busy_clear", 32'(cfg_busy), 32'd0);
        cyc(); quiet(); settle();
        check("t6_single_drain", 32'(cfg_busy), 32'd0);

        // Idle reconfiguration: two-cycle switch
        cyc(); quiet(); cfg_valid = 1'b1; cfg_nsaid = 4'd2;
        cyc(); quiet(); send_aw(32'h9000, 6'd0); settle();
        check("t8_busy", 32'(cfg_busy), 32'd1);
        check("t8_aw_gated", 32'(mst_req.aw_valid), 32'd0);
        cyc(); quiet(); send_aw(32'h9000, 6'd0); settle();
        check("t8_nsaid", 32'(nsaid), 32'd2);
        check("t8_aw_nsaid", 32'(mst_req.aw.nsaid), 32'd2);
        check("t8_aw_ok", 32'(slv_resp.aw_ready), 32'd1);

        // Asynchronous reset with a write outstanding
        cyc(); quiet(); settle();
        check("t9_wr_before", 32'(wr_cnt), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t9_wr_reset", 32'(wr_cnt), 32'd0);
        check("t9_nsaid_reset", 32'(nsaid), 32'd3);
        slv_req  = '0;
        mst_resp = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(); quiet();
        cyc(); quiet(); settle();
        check("t9_idle_wr", 32'(wr_cnt), 32'd0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
